// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_STALL = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } sram_state_e;

endpackage

// File: rtl/ahb_lane_decode.sv
// Maps HSIZE + HADDR[1:0] to a byte-lane mask and a size/alignment legality flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: hsize_i / addr_lo_i in; lanes_o (bit n = byte lane n), legal_o out.
module ahb_lane_decode
    import ahb_lite_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] lanes_o,
    output logic       legal_o
);

    always_comb begin
        lanes_o = 4'b0000;
        legal_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: begin
                lanes_o = 4'b0001 << addr_lo_i;
                legal_o = 1'b1;
            end
            HSIZE_HALF: begin
                lanes_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                legal_o = ~addr_lo_i[0];
            end
            HSIZE_WORD: begin
                lanes_o = 4'b1111;
                legal_o = (addr_lo_i == 2'b00);
            end
            default: begin
                lanes_o = 4'b0000;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a single-port, one-cycle-latency SRAM of four byte banks.
// Latency: zero-wait reads/writes; a read right after a write waits one cycle (none with AHB_SRAM_WRBUF_EN).
// Backpressure: HREADYOUT low only in STALL and ERR1; illegal transfers get a two-cycle ERROR.
// Ports: AHB-Lite slave side (HSEL..HRESP) and RAM side (mem_addr_o, mem_ce_o, mem_we_o,
// mem_din_o, mem_dout_i). Optional macro AHB_SRAM_WRBUF_EN adds a one-entry write buffer
// that removes the read-after-write stall.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] BASE_HI = 16'h0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_ce_o,
    output logic [3:0]        mem_we_o,
    output logic [31:0]       mem_din_o,
    input  logic [31:0]       mem_dout_i
);

    sram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]        wr_lanes_q, wr_lanes_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    logic [3:0]        dec_lanes;
    logic              size_ok;
    logic [13:0]       word_idx;
    logic              range_ok;
    logic              legal;
    logic              accept;
    logic              can_accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              bad_acc;
    logic [ADDR_W-1:0] haddr_word;
    logic [31:0]       rdata;

    ahb_lane_decode u_lane_decode (
        .hsize_i   (HSIZE),
        .addr_lo_i (HADDR[1:0]),
        .lanes_o   (dec_lanes),
        .legal_o   (size_ok)
    );

    // Word-index bits above the RAM size must be zero so small RAMs do not alias.
    assign word_idx   = HADDR[15:2];
    assign range_ok   = (HADDR[31:16] == BASE_HI) && ((word_idx >> ADDR_W) == 14'd0);
    assign legal      = size_ok & range_ok;
    assign haddr_word = HADDR[ADDR_W+1:2];

    // STALL and ERR1 hold HREADYOUT low, so no address phase completes in them.
    assign can_accept = (state_q != ST_STALL) && (state_q != ST_ERR1);
    assign accept     = HSEL & HREADY & can_accept &
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign rd_acc     = accept & legal & ~HWRITE;
    assign wr_acc     = accept & legal & HWRITE;
    assign bad_acc    = accept & ~legal;

`ifdef AHB_SRAM_WRBUF_EN
    logic              buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [3:0]        buf_lanes_q, buf_lanes_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic              buf_hit;

    assign buf_hit = buf_vld_q && (buf_addr_q == rd_addr_q);
`endif

    // Next-state and address-phase capture.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_lanes_d = wr_lanes_q;
        rd_addr_d  = rd_addr_q;
        case (state_q)
            ST_STALL: state_d = ST_RD;
            ST_ERR1:  state_d = ST_ERR2;
            default: begin
                if (bad_acc) begin
                    state_d = ST_ERR1;
                end else if (wr_acc) begin
                    state_d    = ST_WR;
                    wr_addr_d  = haddr_word;
                    wr_lanes_d = dec_lanes;
                end else if (rd_acc) begin
                    rd_addr_d = haddr_word;
`ifdef AHB_SRAM_WRBUF_EN
                    state_d   = ST_RD;
`else
                    // The RAM port is busy with the write data phase this cycle.
                    state_d   = (state_q == ST_WR) ? ST_STALL : ST_RD;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // RAM port arbitration.
    always_comb begin
        mem_addr_o = haddr_word;
        mem_ce_o   = 1'b0;
        mem_we_o   = 4'b0000;
        mem_din_o  = HWDATA;
`ifdef AHB_SRAM_WRBUF_EN
        buf_vld_d   = buf_vld_q;
        buf_addr_d  = buf_addr_q;
        buf_lanes_d = buf_lanes_q;
        buf_data_d  = buf_data_q;
        if ((state_q == ST_WR) && rd_acc) begin
            // Read wins the port; park the write. The buffer is always empty here:
            // it is drained in the cycle that carried this write's address phase.
            buf_vld_d   = 1'b1;
            buf_addr_d  = wr_addr_q;
            buf_lanes_d = wr_lanes_q;
            buf_data_d  = HWDATA;
            mem_ce_o    = 1'b1;
        end else if (state_q == ST_WR) begin
            mem_addr_o = wr_addr_q;
            mem_ce_o   = 1'b1;
            mem_we_o   = wr_lanes_q;
        end else if (rd_acc) begin
            mem_ce_o = 1'b1;
        end else if (buf_vld_q) begin
            mem_addr_o = buf_addr_q;
            mem_ce_o   = 1'b1;
            mem_we_o   = buf_lanes_q;
            mem_din_o  = buf_data_q;
            buf_vld_d  = 1'b0;
        end
`else
        if (state_q == ST_WR) begin
            mem_addr_o = wr_addr_q;
            mem_ce_o   = 1'b1;
            mem_we_o   = wr_lanes_q;
        end else if (state_q == ST_STALL) begin
            mem_addr_o = rd_addr_q;
            mem_ce_o   = 1'b1;
        end else if (rd_acc) begin
            mem_ce_o = 1'b1;
        end
`endif
    end

    // Read data: full word; buffered lanes overlay stale RAM data.
    always_comb begin
        rdata = mem_dout_i;
`ifdef AHB_SRAM_WRBUF_EN
        for (int n = 0; n < 4; n++) begin
            if (buf_hit && buf_lanes_q[n]) begin
                rdata[8*n +: 8] = buf_data_q[8*n +: 8];
            end
        end
`endif
        HRDATA = (state_q == ST_RD) ? rdata : 32'd0;
    end

    assign HREADYOUT = (state_q != ST_STALL) && (state_q != ST_ERR1);
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            wr_lanes_q <= 4'b0000;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_lanes_q <= wr_lanes_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

`ifdef AHB_SRAM_WRBUF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_vld_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_lanes_q <= 4'b0000;
            buf_data_q  <= 32'd0;
        end else begin
            buf_vld_q   <= buf_vld_d;
            buf_addr_q  <= buf_addr_d;
            buf_lanes_q <= buf_lanes_d;
            buf_data_q  <= buf_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave with a byte-lane RAM model and a read scoreboard.
// Latency: n/a.
// Backpressure: the bus master model holds each address phase until HREADYOUT is high.
module tb_ahb_lite_sram_slave;
    import ahb_lite_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [9:0]  mem_addr_o;
    logic        mem_ce_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_din_o;
    logic [31:0] mem_dout_i;

    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] sb [$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_cnt = 0;
    bit          dp_rd = 0, dp_wr = 0, cur_rd = 0, cur_wr = 0;
    logic [31:0] nxt_wdata = 32'd0;

`ifdef AHB_SRAM_WRBUF_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    always #5 clk_i = ~clk_i;
    assign HREADY = HREADYOUT;

    ahb_lite_sram_slave dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP),
        .mem_addr_o (mem_addr_o),
        .mem_ce_o   (mem_ce_o),
        .mem_we_o   (mem_we_o),
        .mem_din_o  (mem_din_o),
        .mem_dout_i (mem_dout_i)
    );

    // Synchronous single-port RAM, one-cycle read latency, per-byte write enables.
    always @(posedge clk_i) begin
        if (mem_ce_o) begin
            for (int n = 0; n < 4; n++) begin
                if (mem_we_o[n]) ram[mem_addr_o][8*n +: 8] <= mem_din_o[8*n +: 8];
            end
            mem_dout_i <= ram[mem_addr_o];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] tb_lanes(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            3'd0:    return 4'b0001 << lo;
            3'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Present an address phase; legal reads push their expected data, legal writes update the model.
    task automatic drive(input bit sel, input logic [1:0] trans, input bit wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit legal);
        logic [3:0] ln;
        HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
        cur_rd = sel & trans[1] & ~wr & legal;
        cur_wr = sel & trans[1] & wr & legal;
        if (cur_rd) sb.push_back(ref_mem[addr[11:2]]);
        if (cur_wr) begin
            nxt_wdata = wdata;
            ln = tb_lanes(size, addr[1:0]);
            for (int n = 0; n < 4; n++) begin
                if (ln[n]) ref_mem[addr[11:2]][8*n +: 8] = wdata[8*n +: 8];
            end
        end
    endtask

    // One clock: sample at negedge, complete data phases, then return #1 after posedge.
    task automatic tick(output bit took);
        @(negedge clk_i);
        took = HREADYOUT;
        if (!HREADYOUT) stall_cnt++;
        if (HREADYOUT) begin
            if (dp_rd) check("hrdata", HRDATA, sb.pop_front());
            dp_rd = cur_rd;
            dp_wr = cur_wr;
        end
        @(posedge clk_i);
        #1;
        if (took && dp_wr) HWDATA = nxt_wdata;
    endtask

    task automatic issue(input bit sel, input logic [1:0] trans, input bit wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit legal);
        bit took;
        drive(sel, trans, wr, size, addr, wdata, legal);
        took = 1'b0;
        for (int k = 0; k < 8 && !took; k++) tick(took);
        check("accept", {31'd0, took}, 32'd1);
    endtask

    task automatic idle();
        issue(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        bit          took;
        int          s0;
        logic [31:0] saved;

        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 32'h1000_0000 + i * 32'h0001_0101;
            ref_mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
        end
        mem_dout_i = 32'd0;
        rst_i = 1'b0;
        HSEL = 1'b0; HADDR = 32'd0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HSIZE = HSIZE_WORD; HWDATA = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_we", {28'd0, mem_we_o}, 32'd0);
        check("rst_ce", {31'd0, mem_ce_o}, 32'd0);
        rst_i = 1'b1;

        // Word write then read of the same word.
        s0 = stall_cnt;
        issue(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        issue(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'd0, 1'b1);
        idle(); idle();
        check("raw_wait_cycles", stall_cnt - s0, EXP_STALL);

        // Byte write into lane 3 over a known word.
        issue(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0020, 32'h1122_3344, 1'b1);
        issue(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h0000_0023, 32'hA500_0000, 1'b1);
        check("byte_we", {28'd0, mem_we_o}, 32'h8);
        issue(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0020, 32'd0, 1'b1);
        idle(); idle();
        check("byte_merge_model", ref_mem[8], 32'hA522_3344);

        // Eight back-to-back reads: no wait states.
        s0 = stall_cnt;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'(i * 4), 32'd0, 1'b1);
        end
        idle(); idle();
        check("burst_wait_cycles", stall_cnt - s0, 0);

        // BUSY is accepted with no action.
        issue(1'b1, HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'd0, 1'b0);
        check("busy_hresp", {31'd0, HRESP}, 32'd0);
        check("busy_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        idle();

        // Misaligned halfword read: two-cycle ERROR, no RAM activity.
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h0000_0001, 32'd0, 1'b0);
        #1;
        check("err_ap_ce", {31'd0, mem_ce_o}, 32'd0);
        tick(took);
        drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'd0, 32'd0, 1'b0);
        check("err1_hreadyout", {31'd0, HREADYOUT}, 32'd0);
        check("err1_hresp", {31'd0, HRESP}, 32'd1);
        check("err1_ce", {31'd0, mem_ce_o}, 32'd0);
        check("err1_we", {28'd0, mem_we_o}, 32'd0);
        tick(took);
        check("err2_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("err2_hresp", {31'd0, HRESP}, 32'd1);
        check("err2_ce", {31'd0, mem_ce_o}, 32'd0);
        check("err2_we", {28'd0, mem_we_o}, 32'd0);
        tick(took);
        check("post_err_hresp", {31'd0, HRESP}, 32'd0);

        // Out-of-base read, then a legal read presented during ERR2.
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h1001_0000, 32'd0, 1'b0);
        tick(took);
        check("base_err1_hresp", {31'd0, HRESP}, 32'd1);
        check("base_err1_hreadyout", {31'd0, HREADYOUT}, 32'd0);
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0020, 32'd0, 1'b1);
        tick(took);
        check("base_err2_hresp", {31'd0, HRESP}, 32'd1);
        check("base_err2_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        tick(took);
        check("err2_accept", {31'd0, took}, 32'd1);
        idle(); idle();

        // Reset during a write data phase: write is dropped.
        saved = ref_mem[12];
        issue(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0030, 32'hCAFE_F00D, 1'b1);
        drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'd0, 32'd0, 1'b0);
        check("wr_phase_we", {28'd0, mem_we_o}, 32'hF);
        rst_i = 1'b0;
        #1;
        check("rst_mid_we", {28'd0, mem_we_o}, 32'd0);
        check("rst_mid_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_mid_hresp", {31'd0, HRESP}, 32'd0);
        ref_mem[12] = saved;
        dp_rd = 0; dp_wr = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        issue(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0030, 32'd0, 1'b1);
        idle(); idle();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
